// File: rtl/sipo_deser.sv
// +----------------------------------------------------------------------------
// | sipo_deser: LSB-first serial-to-parallel deserializer with a valid/ready
// | output, word-boundary sync, and a sticky overrun flag.
// | Optional even-parity bit after each word: define SIPO_PARITY_CHECK_EN.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module sipo_deser #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             clr_overrun,
  output logic             par_err,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

  // Without parity the final bit goes straight from sin into the word, so
  // only WIDTH-1 bits need storing; with parity the whole word waits in S_PAR.
`ifdef SIPO_PARITY_CHECK_EN
  localparam int SR_W = WIDTH;
  localparam logic [CNT_W-1:0] c_PAR_CNT = CNT_W'(WIDTH);
  localparam logic [0:0] S_DATA = 1'b0;
  localparam logic [0:0] S_PAR  = 1'b1;
  logic [0:0] state_q, state_d;
  logic       par_err_q, par_err_d;
  logic       word_perr;
`else
  localparam int SR_W = WIDTH - 1;
`endif

  logic [SR_W-1:0]  sr_q, sr_d, sr_base;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
  logic             word_done;
  logic [WIDTH-1:0] word;
  logic             slot_free;

  // State register and all datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
      state_q     <= S_DATA;
      par_err_q   <= 1'b0;
`endif
    end else begin
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
`ifdef SIPO_PARITY_CHECK_EN
      state_q     <= state_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

`ifdef SIPO_PARITY_CHECK_EN
  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (sync) begin
      state_d = S_DATA;
    end else if (sin_valid) begin
      if (state_q == S_PAR) begin
        state_d = S_DATA;
      end else if (cnt_q == c_LAST_BIT) begin
        state_d = S_PAR;
      end
    end
  end
`endif

  // Bit collection and word assembly
  always_comb begin
    sr_base   = sync ? '0 : sr_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
    word      = sr_q;
    word_perr = 1'b0;
`else
    word      = {sin, sr_q};
`endif
    if (sync) begin
      sr_d  = '0;
      cnt_d = '0;
      if (sin_valid) begin
        sr_d  = SR_W'({sin, sr_base} >> 1);
        cnt_d = c_ONE;
      end
    end else if (sin_valid) begin
`ifdef SIPO_PARITY_CHECK_EN
      if (state_q == S_PAR) begin
        word_done = 1'b1;
        word_perr = ^{sin, sr_q};
        cnt_d     = '0;
      end else begin
        sr_d  = SR_W'({sin, sr_base} >> 1);
        cnt_d = (cnt_q == c_LAST_BIT) ? c_PAR_CNT : cnt_q + c_ONE;
      end
`else
      sr_d = SR_W'({sin, sr_base} >> 1);
      if (cnt_q == c_LAST_BIT) begin
        word_done = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + c_ONE;
      end
`endif
    end
  end

  // Output slot: a pop in the same cycle frees it for a back-to-back word
  always_comb begin
    slot_free   = !out_valid_q || out_ready;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
`ifdef SIPO_PARITY_CHECK_EN
    par_err_d   = par_err_q;
`endif
    if (clr_overrun) begin
      overrun_d = 1'b0;
    end
    if (word_done) begin
      if (slot_free) begin
        out_data_d  = word;
        out_valid_d = 1'b1;
`ifdef SIPO_PARITY_CHECK_EN
        par_err_d   = word_perr;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output assignments
  always_comb begin
    out_data  = out_data_q;
    out_valid = out_valid_q;
    overrun   = overrun_q;
    bit_cnt   = cnt_q;
`ifdef SIPO_PARITY_CHECK_EN
    par_err   = par_err_q;
`else
    par_err   = 1'b0;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_sipo_deser.sv
// +----------------------------------------------------------------------------
// | tb_sipo_deser: directed self-checking bench for sipo_deser (WIDTH=4).
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_sipo_deser;

  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             sin;
  logic             sin_valid;
  logic             sync;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             clr_overrun;
  logic             par_err;
  logic [CNT_W-1:0] bit_cnt;

  int checks = 0;
  int errors = 0;

  sipo_deser #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .sin         (sin),
    .sin_valid   (sin_valid),
    .sync        (sync),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .par_err     (par_err),
    .bit_cnt     (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit gap);
    sin       = b;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
    if (gap) tick();
  endtask

  // Sends one word LSB first (plus its even-parity bit in the parity build);
  // with pop_last, out_ready is raised for the word's completing bit.
  task automatic send_word(input logic [WIDTH-1:0] w, input bit pop_last);
    for (int i = 0; i < WIDTH; i++) begin
`ifndef SIPO_PARITY_CHECK_EN
      if (pop_last && i == WIDTH - 1) out_ready = 1'b1;
`endif
      send_bit(w[i], 1'b0);
    end
`ifdef SIPO_PARITY_CHECK_EN
    if (pop_last) out_ready = 1'b1;
    send_bit(^w, 1'b0);
`endif
  endtask

  initial begin
    reset = 1'b1; sin = 1'b0; sin_valid = 1'b0; sync = 1'b0;
    out_ready = 1'b0; clr_overrun = 1'b0;
    tick(); tick();
    chk("rst_valid",   out_valid, 0);
    chk("rst_data",    out_data,  0);
    chk("rst_overrun", overrun,   0);
    chk("rst_cnt",     bit_cnt,   0);
    chk("rst_perr",    par_err,   0);
    reset = 1'b0;
    out_ready = 1'b1;

    // Basic word 1,0,1,1 -> D, valid for exactly one cycle
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("t1_cnt2", bit_cnt, 2);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
`ifdef SIPO_PARITY_CHECK_EN
    chk("t1_parcnt", bit_cnt, 4);
    chk("t1_noval",  out_valid, 0);
    send_bit(1'b1, 1'b0);
`endif
    chk("t1_valid",   out_valid, 1);
    chk("t1_data",    out_data,  4'hD);
    chk("t1_overrun", overrun,   0);
    chk("t1_perr",    par_err,   0);
    tick();
    chk("t1_popped",  out_valid, 0);
    chk("t1_hold",    out_data,  4'hD);

    // Gapped input 0,1,1,0 -> 6; count holds through idle cycles
    send_bit(1'b0, 1'b1);
    chk("t2_gap1", bit_cnt, 1);
    send_bit(1'b1, 1'b1);
    chk("t2_gap2", bit_cnt, 2);
    send_bit(1'b1, 1'b1);
    chk("t2_gap3", bit_cnt, 3);
    send_bit(1'b0, 1'b0);
`ifdef SIPO_PARITY_CHECK_EN
    send_bit(1'b0, 1'b0);
`endif
    chk("t2_valid", out_valid, 1);
    chk("t2_data",  out_data,  4'h6);
    tick();

    // Back-pressure: second word is dropped and overrun latches
    out_ready = 1'b0;
    send_word(4'h3, 1'b0);
    chk("t3_first", out_data, 4'h3);
    send_word(4'hA, 1'b0);
    chk("t3_data",    out_data,  4'h3);
    chk("t3_valid",   out_valid, 1);
    chk("t3_overrun", overrun,   1);
    // Set beats clear when both land on the same edge
    clr_overrun = 1'b1;
    send_word(4'h5, 1'b0);
    chk("t3_setwins", overrun,  1);
    chk("t3_data2",   out_data, 4'h3);
    out_ready = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("t3_pop",     out_valid, 0);
    chk("t3_clr",     overrun,   0);

    // Sync with a valid bit: that bit starts a new word (0,1,0,1 -> A)
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    sync = 1'b1; sin = 1'b0; sin_valid = 1'b1;
    tick();
    sync = 1'b0; sin_valid = 1'b0;
    chk("t4_synccnt", bit_cnt, 1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
`ifdef SIPO_PARITY_CHECK_EN
    send_bit(1'b0, 1'b0);
`endif
    chk("t4_valid", out_valid, 1);
    chk("t4_data",  out_data,  4'hA);
    tick();

    // Reset mid-word discards the partial word
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_rstcnt",  bit_cnt, 0);
    chk("t4_rstdata", out_data, 0);
    send_word(4'hF, 1'b0);
    chk("t4_fdata", out_data, 4'hF);
    tick();

    // Sync on the completing bit drops the word with no overrun
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
`ifdef SIPO_PARITY_CHECK_EN
    send_bit(1'b1, 1'b0);
`endif
    sync = 1'b1; sin = 1'b1; sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
    chk("t4_drop_valid", out_valid, 0);
    chk("t4_drop_ovr",   overrun,   0);
    chk("t4_drop_cnt",   bit_cnt,   1);
    tick();
    sync = 1'b0;
    chk("t4_sync_idle",  bit_cnt,   0);

    // Back-to-back: pop coincides with the next word's completion
    send_word(4'h1, 1'b0);
    chk("t5_w1", out_data, 4'h1);
    out_ready = 1'b0;
    send_word(4'h2, 1'b1);
    chk("t5_valid",   out_valid, 1);
    chk("t5_data",    out_data,  4'h2);
    chk("t5_overrun", overrun,   0);
    tick();
    chk("t5_pop", out_valid, 0);

`ifdef SIPO_PARITY_CHECK_EN
    // Wrong parity bit for D is flagged alongside the word
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("t6_data", out_data, 4'hD);
    chk("t6_perr", par_err,  1);
    tick();
    send_word(4'hD, 1'b0);
    chk("t6_perr_ok", par_err, 0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
